key_conditioner: RTL and testbench

Parametrised multi-channel push-button front end for the digital clock. Each of `N_KEYS` raw, asynchronous key inputs is synchronised, debounced and edge-detected. Per channel, the block produces a clean level, a one-cycle press pulse and a one-cycle release pulse. With auto-repeat compiled in, it also produces repeat pulses while a key is held. It sits between the board buttons and the time-setting logic and replaces single-purpose rising-edge pulse generators.

---
 rtl/key_conditioner.sv | 166 ++++++++++++++++
 tb/tb_key_conditioner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: per-channel synchroniser, debouncer and press/release
// pulse generator for push-button inputs, with optional hold auto-repeat.
// Optional feature macro: KEY_AUTOREPEAT_EN (builds the hold counters and
// repeat FSM; when undefined key_repeat is tied to 0).
module key_conditioner #(
  parameter int unsigned N_KEYS          = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned REPEAT_DELAY    = 10000000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (N_KEYS == 0 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES == 0 ||
      REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_param_check
    $error("key_conditioner: parameter out of range");
  end

  logic [N_KEYS-1:0] r_sync [SYNC_STAGES];
  logic [N_KEYS-1:0] w_sync;
  logic [N_KEYS-1:0] r_level;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic [CW-1:0]     r_cnt [N_KEYS];
  logic [N_KEYS-1:0] w_diff;
  logic [N_KEYS-1:0] w_accept;
  logic [N_KEYS-1:0] w_press_acc;
  logic [N_KEYS-1:0] w_rel_acc;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchroniser chain bringing the asynchronous keys into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= key_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  // Accept a level change once the counter has seen enough disagreement.
  always_comb begin
    w_diff   = w_sync ^ r_level;
    w_accept = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      w_accept[i] = w_diff[i] && (r_cnt[i] == C_LAST);
    end
    w_press_acc = w_accept & w_sync;
    w_rel_acc   = w_accept & ~w_sync;
  end

  // Debounce counters, stable level and registered press/release pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) r_cnt[i] <= '0;
    end else begin
      r_level   <= r_level ^ w_accept;
      r_press   <= w_press_acc;
      r_release <= w_rel_acc;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (!w_diff[i] || w_accept[i]) r_cnt[i] <= '0;
        else                           r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HW   = $clog2(HMAX + 1);
  localparam logic [HW-1:0] H_DLY = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] H_PER = HW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REPEAT} rep_state_t;

  rep_state_t        r_state [N_KEYS];
  rep_state_t        w_state_nxt [N_KEYS];
  logic [HW-1:0]     r_hold [N_KEYS];
  logic [HW-1:0]     w_hold_nxt [N_KEYS];
  logic [N_KEYS-1:0] w_rep_fire;
  logic [N_KEYS-1:0] r_repeat;

  // Repeat FSM state, hold counter and registered repeat pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_repeat <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        r_state[i] <= ST_IDLE;
        r_hold[i]  <= '0;
      end
    end else begin
      r_repeat <= w_rep_fire;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_hold[i]  <= w_hold_nxt[i];
      end
    end
  end

  // Next-state logic; a release accept overrides everything, so no repeat
  // pulse can share a cycle with the release pulse.
  always_comb begin
    w_rep_fire = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_hold_nxt[i]  = r_hold[i];
      if (w_rel_acc[i]) begin
        w_state_nxt[i] = ST_IDLE;
        w_hold_nxt[i]  = '0;
      end else begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_press_acc[i]) begin
              w_state_nxt[i] = ST_WAIT;
              w_hold_nxt[i]  = '0;
            end
          end
          ST_WAIT: begin
            if (r_hold[i] == H_DLY) begin
              w_rep_fire[i]  = 1'b1;
              w_hold_nxt[i]  = '0;
              w_state_nxt[i] = ST_REPEAT;
            end else begin
              w_hold_nxt[i] = r_hold[i] + HW'(1);
            end
          end
          ST_REPEAT: begin
            if (r_hold[i] == H_PER) begin
              w_rep_fire[i] = 1'b1;
              w_hold_nxt[i] = '0;
            end else begin
              w_hold_nxt[i] = r_hold[i] + HW'(1);
            end
          end
          default: begin
            w_state_nxt[i] = ST_IDLE;
            w_hold_nxt[i]  = '0;
          end
        endcase
      end
    end
  end

  assign key_repeat = r_repeat;
`else
  assign key_repeat = '0;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner (N_KEYS=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5).
module tb_key_conditioner;

  localparam int NK = 4;
  localparam int SS = 2;
  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RP = 5;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level, key_press, key_release, key_repeat;

  key_conditioner #(
    .N_KEYS(NK), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_repeat(key_repeat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: key samples since reset, edge index, and results.
  logic [NK-1:0] samp [$];
  int            m_n;
  int            m_pedge [NK];
  logic [NK-1:0] m_lvl, m_press, m_rel, m_rep;

  task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // A level flips once the synchronised key has disagreed with it for DB
  // consecutive edges; repeats fall at press+RD+k*RP while still held.
  task automatic model_step();
    logic [NK-1:0] tog;
    int idx;
    logic v;
    bit all;
    if (!rst_n) begin
      samp.delete();
      m_n = 0;
      m_lvl = '0; m_press = '0; m_rel = '0; m_rep = '0;
      for (int i = 0; i < NK; i++) m_pedge[i] = 0;
      return;
    end
    tog = '0;
    for (int i = 0; i < NK; i++) begin
      all = 1'b1;
      for (int j = 0; j < DB; j++) begin
        idx = m_n - SS - j;
        v = (idx < 0) ? 1'b0 : samp[idx][i];
        if (v == m_lvl[i]) all = 1'b0;
      end
      tog[i] = all;
    end
    m_press = tog & ~m_lvl;
    m_rel   = tog & m_lvl;
    m_rep   = '0;
    if (REP_EN) begin
      for (int i = 0; i < NK; i++) begin
        if (m_lvl[i] && !m_rel[i] && (m_n - m_pedge[i]) >= RD &&
            ((m_n - m_pedge[i] - RD) % RP) == 0)
          m_rep[i] = 1'b1;
      end
    end
    for (int i = 0; i < NK; i++) if (m_press[i]) m_pedge[i] = m_n;
    m_lvl = m_lvl ^ tog;
    samp.push_back(key_in);
    m_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_level",   key_level,   m_lvl);
    chk("model_press",   key_press,   m_press);
    chk("model_release", key_release, m_rel);
    chk("model_repeat",  key_repeat,  m_rep);
  endtask

  typedef struct {
    logic [NK-1:0] keys;
    int            cycles;
    logic [NK-1:0] lvl;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [NK-1:0] acc_p, acc_r;
    logic [NK-1:0] e_lvl, e_p, e_r, e_rep;
    int div;

    rst_n  = 1'b0;
    key_in = '0;
    tbl.push_back('{4'b0000, 12, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{4'b0001,  9, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{4'b0001,  1, 4'b0001, 4'b0001, 4'b0000});
    tbl.push_back('{4'b0001,  5, 4'b0001, 4'b0000, 4'b0000});
    tbl.push_back('{4'b0011,  5, 4'b0001, 4'b0000, 4'b0000});
    tbl.push_back('{4'b0001,  2, 4'b0001, 4'b0000, 4'b0000});
    tbl.push_back('{4'b0011,  9, 4'b0001, 4'b0000, 4'b0000});
    tbl.push_back('{4'b0011,  1, 4'b0011, 4'b0010, 4'b0000});
    tbl.push_back('{4'b0001,  7, 4'b0011, 4'b0000, 4'b0000});
    tbl.push_back('{4'b0011, 12, 4'b0011, 4'b0000, 4'b0000});
    tbl.push_back('{4'b0000,  9, 4'b0011, 4'b0000, 4'b0000});
    tbl.push_back('{4'b0000,  1, 4'b0000, 4'b0000, 4'b0011});
    tbl.push_back('{4'b0000,  5, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{4'b1001,  9, 4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{4'b1001,  1, 4'b1001, 4'b1001, 4'b0000});
    tbl.push_back('{4'b0000, 15, 4'b0000, 4'b0000, 4'b1001});

    repeat (3) tick();
    chk("reset_level",   key_level,   4'b0000);
    chk("reset_press",   key_press,   4'b0000);
    chk("reset_release", key_release, 4'b0000);
    chk("reset_repeat",  key_repeat,  4'b0000);
    rst_n = 1'b1;

    // Table-driven segments: press/release ORed over the segment.
    for (int r = 0; r < tbl.size(); r++) begin
      key_in = tbl[r].keys;
      acc_p = '0;
      acc_r = '0;
      for (int c = 0; c < tbl[r].cycles; c++) begin
        tick();
        acc_p |= key_press;
        acc_r |= key_release;
      end
      chk($sformatf("tbl%0d_level", r),   key_level, tbl[r].lvl);
      chk($sformatf("tbl%0d_press", r),   acc_p,     tbl[r].press);
      chk($sformatf("tbl%0d_release", r), acc_r,     tbl[r].rel);
    end

    // Key 2 held 60 cycles: press at 10, repeats 30,35,..,65, release at 70
    // (the repeat slot at 70 coincides with the release and is suppressed).
    for (int t = 1; t <= 80; t++) begin
      key_in = (t <= 60) ? 4'b0100 : 4'b0000;
      tick();
      e_lvl = (t >= 10 && t < 70) ? 4'b0100 : 4'b0000;
      e_p   = (t == 10) ? 4'b0100 : 4'b0000;
      e_r   = (t == 70) ? 4'b0100 : 4'b0000;
      e_rep = (REP_EN && t >= 30 && t < 70 && ((t - 30) % RP) == 0) ? 4'b0100 : 4'b0000;
      chk("hold_level",   key_level,   e_lvl);
      chk("hold_press",   key_press,   e_p);
      chk("hold_release", key_release, e_r);
      chk("hold_repeat",  key_repeat,  e_rep);
    end

    // Reset at cycle 15 of a hold, then the held key is re-pressed.
    key_in = 4'b0001;
    repeat (15) tick();
    chk("prerst_level", key_level, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("async_level",   key_level,   4'b0000);
    chk("async_press",   key_press,   4'b0000);
    chk("async_release", key_release, 4'b0000);
    chk("async_repeat",  key_repeat,  4'b0000);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk("rerst_press", key_press, (t == 10) ? 4'b0001 : 4'b0000);
      chk("rerst_level", key_level, (t >= 10) ? 4'b0001 : 4'b0000);
    end
    key_in = '0;
    repeat (15) tick();

    // Random toggling: short runs first, then long holds, one reset inside.
    for (int c = 0; c < 3600; c++) begin
      div = (c < 1500) ? 12 : 60;
      for (int b = 0; b < NK; b++)
        if ($urandom_range(div - 1) == 0) key_in[b] = ~key_in[b];
      if (c == 900) rst_n = 1'b0;
      if (c == 903) rst_n = 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
